// File: rtl/fetch_top.sv
// rtl/fetch_top.sv - instruction fetch unit: sequential fetch, response FIFO, redirect flush
// Optional FETCH_BYPASS_EN: a response to an empty FIFO is presented to decode in the same cycle.
module fetch_top #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] resp_pc;
  logic [CW-1:0]         count;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         discard;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pc   [DEPTH];

  logic [CW:0] used;
  logic        head_valid;
  logic        keep_rsp;
  logic        bypass;
  logic        push;
  logic        pop;

  // Credit counts buffered words plus responses that will still be kept.
  assign used       = {1'b0, count} + {1'b0, inflight - discard};
  assign imem_req   = rst && !redirect && (inflight < DEPTH_C) && (used < DEPTH_W);
  assign imem_addr  = pc;

  assign head_valid = (count != '0);
  assign keep_rsp   = imem_rvalid && (discard == '0) && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = !head_valid && keep_rsp;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = (head_valid || bypass) && !redirect;
  assign instr       = bypass ? imem_rdata : mem_data[rd_ptr];
  assign instr_pc    = bypass ? resp_pc    : mem_pc[rd_ptr];

  assign pop  = instr_valid && instr_ready && head_valid;
  assign push = keep_rsp && !(bypass && instr_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (redirect) begin
      // Everything still outstanding after this cycle is stale and must be dropped.
      pc       <= redirect_pc;
      resp_pc  <= redirect_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= inflight - CW'(imem_rvalid);
      discard  <= inflight - CW'(imem_rvalid);
    end else begin
      if (imem_req) begin
        pc <= pc + DATA_WIDTH'(4);
      end
      inflight <= inflight + CW'(imem_req) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (keep_rsp) begin
        resp_pc <= resp_pc + DATA_WIDTH'(4);
      end
      if (push) begin
        mem_data[wr_ptr] <= imem_rdata;
        mem_pc[wr_ptr]   <= resp_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_top.sv
// tb/tb_fetch_top.sv - directed bench for fetch_top with an in-order variable-latency memory model
module tb_fetch_top;

`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] exp_pc   = 32'h0;
  int          n_deliv  = 0;
  int          first;
  int          d0;

  fetch_top dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory returns the bitwise inverse of the address, so every word is tied to its PC.
  task automatic monitor();
    if (redirect) check_eq("valid_in_redirect", 32'(instr_valid), 32'd0);
    if (instr_valid && instr_ready) begin
      check_eq("instr_pc_seq", instr_pc, exp_pc);
      check_eq("instr_word", instr, ~exp_pc);
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
  endtask

  task automatic drive_mem();
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~q_addr[0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic adv();
    logic        rq;
    logic [31:0] ra;
    rq = imem_req;
    ra = imem_addr;
    @(posedge clk);
    if (imem_rvalid) begin
      q_addr.delete(0);
      q_due.delete(0);
    end
    if (rq && rst) begin
      q_addr.push_back(ra);
      q_due.push_back(cyc + lat);
    end
    cyc++;
    if (redirect) exp_pc = redirect_pc;
    #1;
    drive_mem();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
      adv();
    end
  endtask

  task automatic do_reset(input int new_lat);
    #1 rst = 1'b0;
    q_addr.delete();
    q_due.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    lat         = new_lat;
    exp_pc      = 32'h0;
    #1;
    check_eq("rst_imem_req", 32'(imem_req), 32'd0);
    check_eq("rst_imem_addr", imem_addr, 32'h0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    step(1);
    rst = 1'b1;
  endtask

  task automatic wait_first(input string tag, input logic [31:0] pc0, input int exp_k);
    first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (instr_valid && first < 0) begin
        first = k;
        check_eq({tag, "_first_pc"}, instr_pc, pc0);
      end
      monitor();
      adv();
    end
    check_eq({tag, "_latency"}, 32'(first), 32'(exp_k));
  endtask

  initial begin
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;

    // Ramp from reset at latency 1: one request and, later, one delivery per cycle.
    do_reset(1);
    first = -1;
    d0    = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_eq("ramp_req", 32'(imem_req), 32'd1);
      check_eq("ramp_addr", imem_addr, 32'(4 * k));
      if (instr_valid && first < 0) first = k;
      if (k == 4) d0 = n_deliv;
      monitor();
      adv();
    end
    check_eq("req_to_valid", 32'(first), 32'(EXP_LAT));
    check_eq("throughput", 32'(n_deliv - d0), 32'd8);

    // Decode stalled from reset: four requests then credit runs out.
    instr_ready = 1'b0;
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("stall_req", 32'(imem_req), 32'(k < 4));
      if (k == 9) begin
        check_eq("stall_valid", 32'(instr_valid), 32'd1);
        check_eq("stall_head_pc", instr_pc, 32'h0);
        check_eq("stall_head_word", instr, 32'hFFFF_FFFF);
      end
      monitor();
      adv();
    end
    instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check_eq("drain_valid", 32'(instr_valid), 32'd1);
      check_eq("drain_pc", instr_pc, 32'(4 * j));
      monitor();
      adv();
    end
    step(6);

    // Latency 3, three in flight, redirect in the cycle the first response lands.
    do_reset(3);
    step(3);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check_eq("redir_req", 32'(imem_req), 32'd0);
    check_eq("redir_valid", 32'(instr_valid), 32'd0);
    monitor();
    adv();
    redirect = 1'b0;
    @(negedge clk);
    check_eq("redir_next_req", 32'(imem_req), 32'd1);
    check_eq("redir_next_addr", imem_addr, 32'h100);
    monitor();
    adv();
    wait_first("redir", 32'h100, EXP_LAT + 1);

    // Back-to-back redirects: the second target wins.
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    check_eq("b2b_req_a", 32'(imem_req), 32'd0);
    check_eq("b2b_valid_a", 32'(instr_valid), 32'd0);
    monitor();
    adv();
    redirect_pc = 32'h300;
    @(negedge clk);
    check_eq("b2b_req_b", 32'(imem_req), 32'd0);
    check_eq("b2b_valid_b", 32'(instr_valid), 32'd0);
    monitor();
    adv();
    redirect = 1'b0;
    @(negedge clk);
    check_eq("b2b_resume_addr", imem_addr, 32'h300);
    check_eq("b2b_resume_req", 32'(imem_req), 32'd1);
    monitor();
    adv();
    wait_first("b2b", 32'h300, EXP_LAT + 1);

    // Fill the FIFO, then reset asynchronously mid-cycle and restart.
    instr_ready = 1'b0;
    step(12);
    @(negedge clk);
    check_eq("full_valid", 32'(instr_valid), 32'd1);
    check_eq("full_req", 32'(imem_req), 32'd0);
    check_eq("full_head", instr_pc, exp_pc);
    monitor();
    adv();
    instr_ready = 1'b1;
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("restart_addr", imem_addr, 32'(4 * k));
      monitor();
      adv();
    end
    check_eq("restart_deliv", exp_pc, 32'(4 * (8 - EXP_LAT)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
